// File: rtl/fanout_fork.sv
// Broadcast fork: one valid/ready stream fanned out to NUM_OUT masked consumers,
// lazy (all-ready merge) or eager (per-consumer served tracking). Optional stall counter: FANOUT_FORK_PERF_EN.
module fanout_fork #(
  parameter int NUM_OUT    = 9,
  parameter int DATA_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [NUM_OUT-1:0]    cfg_mask,
  input  logic                  cfg_eager,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [NUM_OUT-1:0]    out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [NUM_OUT-1:0]    out_ready
`ifdef FANOUT_FORK_PERF_EN
  ,
  output logic [15:0]           perf_stall
`endif
);

  logic [NUM_OUT-1:0] served;
  logic [NUM_OUT-1:0] take;
  logic [NUM_OUT-1:0] done;
  logic               all_ready;

  assign out_data = in_data;

  always_comb begin
    done      = ~cfg_mask | served | out_ready;
    all_ready = &(~cfg_mask | out_ready);
    in_ready  = 1'b0;
    out_valid = '0;
    if (cfg_eager) begin
      out_valid = {NUM_OUT{in_valid}} & cfg_mask & ~served;
      // never report ready for a word that has not been offered yet
      in_ready  = in_valid & (&done);
    end else begin
      in_ready  = all_ready;
      out_valid = {NUM_OUT{in_valid & all_ready}} & cfg_mask;
    end
    take = out_valid & out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      served <= '0;
    end else if (clk_en) begin
      if (!cfg_eager || (in_valid && in_ready)) begin
        served <= '0;
      end else begin
        served <= served | take;
      end
    end
  end

`ifdef FANOUT_FORK_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall <= '0;
    end else if (clk_en && in_valid && !in_ready && (perf_stall != 16'hFFFF)) begin
      perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fanout_fork.sv
// Directed bench for fanout_fork: per-consumer handshake scoreboard plus
// immediate-assertion checks of the combinational handshake outputs.
module tb_fanout_fork;
  localparam int N = 9;
  localparam int W = 17;

  logic         clk = 1'b0;
  logic         rst;
  logic         clk_en;
  logic [N-1:0] cfg_mask;
  logic         cfg_eager;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [N-1:0] out_valid;
  logic [W-1:0] out_data;
  logic [N-1:0] out_ready;
`ifdef FANOUT_FORK_PERF_EN
  logic [15:0]  perf_stall;
`endif

  fanout_fork #(.NUM_OUT(N), .DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .cfg_mask  (cfg_mask),
    .cfg_eager (cfg_eager),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef FANOUT_FORK_PERF_EN
    ,
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           ch;
    logic [W-1:0] data;
  } take_t;

  take_t exp_q[$];
  int    errs   = 0;
  int    checks = 0;
  int    acc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [W-1:0] d);
    take_t t;
    t.ch   = ch;
    t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic push_mask(input logic [N-1:0] m, input logic [W-1:0] d);
    for (int i = 0; i < N; i++) if (m[i]) push(i, d);
  endtask

  // Pops one scoreboard entry per consumer handshake seen this cycle.
  task automatic scan();
    take_t t;
    if (in_valid && in_ready) acc++;
    for (int i = 0; i < N; i++) begin
      if (out_valid[i] && out_ready[i]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $error("FAIL extra_take: got take on ch %0d expected none", i);
        end else begin
          t = exp_q.pop_front();
          chk("take_ch", 32'(i), 32'(t.ch));
          chk("take_data", 32'(out_data), 32'(t.data));
        end
      end
    end
  endtask

  task automatic cyc(input logic [N-1:0] m, input logic e, input logic v,
                     input logic [W-1:0] d, input logic [N-1:0] r, input logic en);
    @(negedge clk);
    cfg_mask  = m;
    cfg_eager = e;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clk_en    = en;
    #1;
    if (en) scan();
  endtask

  task automatic sb_drained(input string tag);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  int acc0;

  initial begin
    rst = 1'b1; clk_en = 1'b1; cfg_mask = 9'h1FF; cfg_eager = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // lazy broadcast
    acc0 = acc;
    for (int k = 0; k < 4; k++) begin
      push_mask(9'h1FF, 17'h00A5);
      cyc(9'h1FF, 1'b0, 1'b1, 17'h00A5, 9'h1FF, 1'b1);
      chk("lazy_bc_in_ready", 32'(in_ready), 32'h1);
      chk("lazy_bc_out_valid", 32'(out_valid), 32'h1FF);
    end
    chk("lazy_bc_words", 32'(acc - acc0), 32'd4);
    sb_drained("lazy_bc_drained");

    // lazy stall then release
    cyc(9'h005, 1'b0, 1'b1, 17'h1234, 9'h001, 1'b1);
    chk("lazy_stall_in_ready", 32'(in_ready), 32'h0);
    chk("lazy_stall_out_valid", 32'(out_valid), 32'h0);
    push_mask(9'h005, 17'h1234);
    cyc(9'h005, 1'b0, 1'b1, 17'h1234, 9'h005, 1'b1);
    chk("lazy_rel_in_ready", 32'(in_ready), 32'h1);
    chk("lazy_rel_out_valid", 32'(out_valid), 32'h005);
    sb_drained("lazy_stall_drained");

    // eager staggered accept
    acc0 = acc;
    push(0, 17'h1ABCD);
    cyc(9'h007, 1'b1, 1'b1, 17'h1ABCD, 9'h001, 1'b1);
    chk("eg_c0_out_valid", 32'(out_valid), 32'h007);
    chk("eg_c0_in_ready", 32'(in_ready), 32'h0);
    push(2, 17'h1ABCD);
    cyc(9'h007, 1'b1, 1'b1, 17'h1ABCD, 9'h005, 1'b1);
    chk("eg_c1_out_valid", 32'(out_valid), 32'h006);
    chk("eg_c1_in_ready", 32'(in_ready), 32'h0);
    push(1, 17'h1ABCD);
    cyc(9'h007, 1'b1, 1'b1, 17'h1ABCD, 9'h002, 1'b1);
    chk("eg_c2_out_valid", 32'(out_valid), 32'h002);
    chk("eg_c2_in_ready", 32'(in_ready), 32'h1);
    cyc(9'h007, 1'b1, 1'b1, 17'h000F0, 9'h000, 1'b1);
    chk("eg_c3_out_valid", 32'(out_valid), 32'h007);
    chk("eg_c3_in_ready", 32'(in_ready), 32'h0);
    chk("eg_words", 32'(acc - acc0), 32'd1);
    sb_drained("eg_stagger_drained");

    // eager back-to-back at full rate
    for (int k = 0; k < 3; k++) begin
      push_mask(9'h007, 17'(32'h00F0 + k));
      cyc(9'h007, 1'b1, 1'b1, 17'(32'h00F0 + k), 9'h007, 1'b1);
      chk("eg_b2b_in_ready", 32'(in_ready), 32'h1);
      chk("eg_b2b_out_valid", 32'(out_valid), 32'h007);
    end
    sb_drained("eg_b2b_drained");

    // clk_en low: handshake state must not advance
    cyc(9'h007, 1'b1, 1'b1, 17'h0077, 9'h001, 1'b0);
    chk("en0_out_valid", 32'(out_valid), 32'h007);
    cyc(9'h007, 1'b1, 1'b1, 17'h0077, 9'h000, 1'b1);
    chk("en0_hold_out_valid", 32'(out_valid), 32'h007);
    push_mask(9'h007, 17'h0077);
    cyc(9'h007, 1'b1, 1'b1, 17'h0077, 9'h007, 1'b1);
    chk("en0_done_in_ready", 32'(in_ready), 32'h1);
    sb_drained("en0_drained");

    // empty mask
    acc0 = acc;
    for (int k = 0; k < 3; k++) begin
      cyc(9'h000, 1'b1, 1'b1, 17'(32'h0300 + k), 9'h1FF, 1'b1);
      chk("empty_in_ready", 32'(in_ready), 32'h1);
      chk("empty_out_valid", 32'(out_valid), 32'h0);
    end
    chk("empty_words", 32'(acc - acc0), 32'd3);
    cyc(9'h000, 1'b0, 1'b0, 17'h0, 9'h000, 1'b1);
    chk("empty_lazy_in_ready", 32'(in_ready), 32'h1);
    cyc(9'h007, 1'b1, 1'b0, 17'h0, 9'h1FF, 1'b1);
    chk("eg_idle_in_ready", 32'(in_ready), 32'h0);
    chk("eg_idle_out_valid", 32'(out_valid), 32'h0);

    // reset mid-transfer
    push_mask(9'h003, 17'h0155);
    cyc(9'h007, 1'b1, 1'b1, 17'h0155, 9'h003, 1'b1);
    chk("mid_c0_out_valid", 32'(out_valid), 32'h007);
    cyc(9'h007, 1'b1, 1'b1, 17'h0155, 9'h000, 1'b1);
    chk("mid_c1_out_valid", 32'(out_valid), 32'h004);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'h007);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(9'h007, 1'b1, 1'b1, 17'h0155, 9'h000, 1'b1);
    chk("mid_rel_out_valid", 32'(out_valid), 32'h007);
    push_mask(9'h007, 17'h0155);
    cyc(9'h007, 1'b1, 1'b1, 17'h0155, 9'h007, 1'b1);
    chk("mid_rel_in_ready", 32'(in_ready), 32'h1);
    sb_drained("mid_drained");

`ifdef FANOUT_FORK_PERF_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("perf_rst", 32'(perf_stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) cyc(9'h001, 1'b1, 1'b1, 17'h0009, 9'h000, 1'b1);
    cyc(9'h001, 1'b1, 1'b0, 17'h0009, 9'h000, 1'b1);
    chk("perf_five", 32'(perf_stall), 32'd5);
    for (int k = 0; k < 65535; k++) cyc(9'h001, 1'b1, 1'b1, 17'h0009, 9'h000, 1'b1);
    cyc(9'h001, 1'b1, 1'b0, 17'h0009, 9'h000, 1'b1);
    chk("perf_sat", 32'(perf_stall), 32'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
